// File: rtl/irq_pkg.sv
// Shared widths, FSM state type and clear-mask helper for the request encoder.
package irq_pkg;

  localparam int unsigned N_REQ  = 8;
  localparam int unsigned CODE_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // One-hot mask selecting the pending bit addressed by a code.
  function automatic logic [N_REQ-1:0] clr_mask(input logic [CODE_W-1:0] c);
    return N_REQ'(1) << c;
  endfunction

endpackage

// File: rtl/pri_enc8_3.sv
// Combinational 8-to-3 priority encoder: index of the highest set bit plus an any-set flag.
module pri_enc8_3
  import irq_pkg::*;
(
  input  logic [N_REQ-1:0]  in,
  output logic [CODE_W-1:0] idx_c,
  output logic              any_c
);

  // Ascending scan so the highest set bit wins.
  always_comb begin
    idx_c = '0;
    any_c = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (in[i]) begin
        idx_c = CODE_W'(i);
        any_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_encoder8_3.sv
// Registered 8-to-3 priority encoder: captures request rising edges into a pending
// register and holds the highest-priority code until acknowledged.
module irq_encoder8_3
  import irq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [N_REQ-1:0]  req,
  input  logic              ack,
  output logic [CODE_W-1:0] code,
  output logic              valid,
  output logic [N_REQ-1:0]  pending
);

  state_t              state;
  state_t              state_n;
  logic [N_REQ-1:0]    req_q;
  logic [N_REQ-1:0]    rise;
  logic [N_REQ-1:0]    clr;
  logic [N_REQ-1:0]    pending_n;
  logic [CODE_W-1:0]   code_n;
  logic                valid_n;
  logic [CODE_W-1:0]   enc_idx_c;
  logic                enc_any_c;

  pri_enc8_3 u_pri_enc (
    .in    (pending),
    .idx_c (enc_idx_c),
    .any_c (enc_any_c)
  );

  assign rise = req & ~req_q;
  // A new rise on the bit being retired keeps it pending.
  assign pending_n = (pending & ~clr) | rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      code    <= '0;
      valid   <= 1'b0;
      pending <= '0;
      req_q   <= '0;
    end else begin
      state   <= state_n;
      code    <= code_n;
      valid   <= valid_n;
      pending <= pending_n;
      req_q   <= req;
    end
  end

  // Grant from IDLE when enabled; hold the code in GRANT until ack retires it.
  always_comb begin
    state_n = state;
    code_n  = code;
    valid_n = valid;
    clr     = '0;
    case (state)
      IDLE: begin
        valid_n = 1'b0;
        if (en && enc_any_c) begin
          code_n  = enc_idx_c;
          valid_n = 1'b1;
          state_n = GRANT;
        end
      end
      GRANT: begin
        if (ack) begin
          clr     = clr_mask(code);
          valid_n = 1'b0;
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        valid_n = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_irq_encoder8_3.sv
// Self-checking bench for irq_encoder8_3: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural model.
module tb_irq_encoder8_3;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] req;
  logic       ack;
  logic [2:0] code;
  logic       valid;
  logic [7:0] pending;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [7:0] m_prev_req;
  logic [7:0] m_pend;
  logic       m_valid;
  logic [2:0] m_code;

  irq_encoder8_3 dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .req     (req),
    .ack     (ack),
    .code    (code),
    .valid   (valid),
    .pending (pending)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] highest(input logic [7:0] p);
    logic [2:0] h;
    h = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (p[i]) begin
        h = 3'(i);
        break;
      end
    end
    return h;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Advance the model by one rising edge using the inputs present at that edge.
  task automatic model_edge();
    logic [7:0] rise_bits;
    logic [7:0] clr_bits;
    logic [7:0] old_pend;
    if (rst) begin
      m_prev_req = 8'h00;
      m_pend     = 8'h00;
      m_valid    = 1'b0;
      m_code     = 3'd0;
    end else begin
      old_pend  = m_pend;
      rise_bits = req & ~m_prev_req;
      clr_bits  = (m_valid && ack) ? (8'h01 << m_code) : 8'h00;
      m_pend    = (old_pend & ~clr_bits) | rise_bits;
      if (m_valid) begin
        if (ack) m_valid = 1'b0;
      end else if (en && (old_pend != 8'h00)) begin
        m_code  = highest(old_pend);
        m_valid = 1'b1;
      end
      m_prev_req = req;
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    chk({tag, ".code"},    8'(code),    8'(m_code));
    chk({tag, ".valid"},   8'(valid),   8'(m_valid));
    chk({tag, ".pending"}, pending,     m_pend);
  endtask

  initial begin
    m_prev_req = 8'h00;
    m_pend     = 8'h00;
    m_valid    = 1'b0;
    m_code     = 3'd0;
    rst = 1'b1; en = 1'b1; req = 8'hFF; ack = 1'b0;

    // Reset with all requests held high
    step("rst0");
    step("rst1");
    chk("rst_code", 8'(code), 8'h00);
    chk("rst_valid", 8'(valid), 8'h00);
    chk("rst_pend", pending, 8'h00);
    rst = 1'b0;
    step("rel0");
    chk("rel_pend", pending, 8'hFF);
    chk("rel_valid", 8'(valid), 8'h00);
    step("rel1");
    chk("rel_grant_code", 8'(code), 8'h07);
    chk("rel_grant_valid", 8'(valid), 8'h01);
    req = 8'h00; ack = 1'b1;
    for (int i = 0; i < 18; i++) step("drain");
    chk("drain_pend", pending, 8'h00);
    ack = 1'b0;
    step("drain_idle");

    // Single request
    req = 8'h04;
    step("single0");
    chk("single_pend", pending, 8'h04);
    req = 8'h00;
    step("single1");
    chk("single_code", 8'(code), 8'h02);
    chk("single_valid", 8'(valid), 8'h01);
    ack = 1'b1;
    step("single_ack");
    chk("single_ack_valid", 8'(valid), 8'h00);
    chk("single_ack_pend", pending, 8'h00);
    ack = 1'b0;

    // Priority without preemption
    req = 8'h02;
    step("pri0");
    step("pri1");
    chk("pri_code1", 8'(code), 8'h01);
    req = 8'h42;
    step("pri2");
    chk("nopre_code", 8'(code), 8'h01);
    chk("nopre_pend", pending, 8'h42);
    ack = 1'b1;
    step("pri_ack");
    chk("pri_ack_valid", 8'(valid), 8'h00);
    ack = 1'b0;
    step("pri3");
    chk("pri_code6", 8'(code), 8'h06);
    chk("pri_valid6", 8'(valid), 8'h01);
    ack = 1'b1; req = 8'h00;
    step("pri_ack2");
    chk("pri_empty", pending, 8'h00);
    ack = 1'b0;

    // Simultaneous set and clear on the granted bit
    req = 8'h08;
    step("sc0");
    req = 8'h00;
    step("sc1");
    chk("sc_code", 8'(code), 8'h03);
    req = 8'h08; ack = 1'b1;
    step("sc2");
    chk("sc_valid", 8'(valid), 8'h00);
    chk("sc_pend", pending, 8'h08);
    req = 8'h00; ack = 1'b0;
    step("sc3");
    chk("sc_regrant", 8'(code), 8'h03);
    chk("sc_regrant_v", 8'(valid), 8'h01);
    ack = 1'b1;
    step("sc4");
    ack = 1'b0;

    // Enable gating and stray ack
    en = 1'b0; req = 8'h10;
    step("en0");
    req = 8'h00;
    step("en1");
    step("en2");
    chk("en_novalid", 8'(valid), 8'h00);
    chk("en_pend", pending, 8'h10);
    ack = 1'b1;
    step("stray");
    chk("stray_pend", pending, 8'h10);
    ack = 1'b0; en = 1'b1;
    step("en3");
    chk("en_code", 8'(code), 8'h04);
    chk("en_valid", 8'(valid), 8'h01);
    ack = 1'b1;
    step("en4");
    ack = 1'b0;

    // Reset in the middle of a grant
    req = 8'h81;
    step("mr0");
    chk("mr_pend", pending, 8'h81);
    step("mr1");
    chk("mr_code", 8'(code), 8'h07);
    rst = 1'b1; req = 8'h00;
    step("mr_rst");
    chk("mr_rst_valid", 8'(valid), 8'h00);
    chk("mr_rst_pend", pending, 8'h00);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step("mr_quiet");
    chk("mr_nogrant", 8'(valid), 8'h00);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      req = 8'($urandom);
      en  = ($urandom_range(0, 3) != 0);
      ack = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 99) == 0);
      step("rand");
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_encoder8_3.md
# irq_encoder8_3

Registered 8-to-3 priority encoder with a request/acknowledge handshake: the encode-direction counterpart of the 3-to-8 decoder used for unit/line select in the datapath. It captures rising edges on eight request lines into a pending register and presents the highest-priority pending index as a stable 3-bit code. The code is held until the consumer acknowledges it, then that pending bit is retired. It sits between the peripheral/interrupt request lines and the control unit, whose decoder side turns the code back into a one-hot select.

## Interface
- Parameters: none; widths are fixed at 8 request lines and a 3-bit code.
- clk  input  1  single system clock, all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  grant enable; when low, no new code is issued
- req  input  8  request lines, rising-edge sensitive, bit 7 = highest priority
- ack  input  1  consumer has taken the current code
- code  output  3  index of the granted request, registered
- valid  output  1  code is valid, registered
- pending  output  8  current pending-request register

## Operation
- Edge capture: req_q <= req every cycle; rise = req & ~req_q.
- pending <= (pending & ~clr) | rise. clr is one-hot of code, asserted only on an accepted ack. Set wins over clear on the same bit.
- FSM states:
  - IDLE: if en && |pending, then code <= index of the highest set pending bit, valid <= 1, go to GRANT. Otherwise remain in IDLE with valid = 0.
  - GRANT: code and valid are held constant. If ack, then valid <= 0, pending[code] is cleared, go to IDLE.
- No preemption: a higher-priority rise during GRANT sets pending but does not change code.
- en low during GRANT does not abort the grant; the block waits for ack.
- ack in IDLE is ignored and clears nothing.
- A req held high across reset deassertion counts as a rise, because req_q resets to 0.
- A held-high req produces only one pending set. A re-request needs a falling edge followed by a rising edge.

## Timing
- Reset values: code = 3'b000, valid = 0, pending = 8'h00, req_q = 8'h00, state = IDLE.
- req[i] high at edge k (was low at edge k-1): pending[i] = 1 after edge k.
- From that point, valid = 1 after edge k+1 if en = 1 and the block is in IDLE. Minimum latency is 2 edges from req to valid.
- ack sampled high at edge m while valid: valid = 0 and pending bit cleared after edge m.
- Next grant, if any pending: valid = 1 after edge m+1. valid is therefore low for at least one cycle between grants.
- rst high at any edge returns all state to reset values. This applies mid-GRANT too; an in-flight grant is dropped and is not retired.

## Structure
- Shared package irq_pkg holds:
  - N_REQ = 8, CODE_W = 3;
  - FSM state typedef {IDLE, GRANT};
  - a function mapping code to a one-hot clear mask.
- One combinational sub-module, pri_enc8_3: 8-bit input, 3-bit highest-set index plus any-set flag. It is instantiated once on pending.
- Expected RTL size: about 150 lines total.

## Test plan
- Reset: hold rst with req = 8'hFF, then release. After reset all outputs are 0. The first edge after release sets pending = 8'hFF; valid = 1 with code = 3'd7 one edge later.
- Single request, en = 1: pulse req[2]. Expect valid = 1 with code = 2 two edges after the rise. ack for one cycle gives valid = 0 and pending = 8'h00.
- Priority and no-preempt:
  - Raise req[1]; it is granted (code = 1).
  - During GRANT, raise req[6]. code stays 1 and pending = 8'h42.
  - After ack, code = 6 is granted one idle cycle later.
- Simultaneous set/clear: in GRANT with code = 3, ack on the same edge as a new rise on req[3]. Expect valid = 0, pending[3] stays 1, and code 3 is re-granted.
- en gating and stray ack:
  - With en = 0 and pending = 8'h10, no valid is issued.
  - ack in IDLE leaves pending unchanged.
  - Raising en gives code = 4 after one edge.
- Reset mid-GRANT: pending = 8'h81, code = 7 valid, then assert rst for 1 cycle. Expect all zero, and no grant until a new rise.
